// File: rtl/dice_craps_engine_if.sv
// Player-facing signal bundle for the craps engine.
//   roll        : raw roll button (1 = pressed), asynchronous to clock
//   disp1/disp2 : die segment drives {g,f,e,d,c,b,a}
//   win/lose    : result LEDs
//   point       : established point, 0 when none
//   point_valid : high while a point is being chased
// master = board/bench side driving the button, slave = engine.
interface dice_craps_engine_if #(
  parameter int FACES = 6
);
  localparam int SUMW = $clog2(2 * FACES + 1);

  logic            roll;
  logic [6:0]      disp1;
  logic [6:0]      disp2;
  logic            win;
  logic            lose;
  logic [SUMW-1:0] point;
  logic            point_valid;

  modport master (
    output roll,
    input  disp1, disp2, win, lose, point, point_valid
  );

  modport slave (
    input  roll,
    output disp1, disp2, win, lose, point, point_valid
  );
endinterface

// File: rtl/dice_craps_engine.sv
// Craps game engine: roll-button synchroniser, two free-running dice
// counters, FIRST/POINT/WIN/LOSE game FSM with optional point-phase roll
// limit, and registered 7-segment / LED outputs.
// Ports:
//   clock : system clock
//   reset : synchronous, active-high
//   bus   : dice_craps_engine_if.slave (roll in; disp1, disp2, win, lose,
//           point, point_valid out). Interface FACES must match this FACES.
module dice_craps_engine #(
  parameter int FACES          = 6,
  parameter int MAX_ROLLS      = 0,
  parameter bit SEG_ACTIVE_LOW = 1
) (
  input  logic               clock,
  input  logic               reset,
  dice_craps_engine_if.slave bus
);
  localparam int SUMW = $clog2(2 * FACES + 1);
  localparam int DW   = $clog2(FACES + 1);
  localparam int CNTW = (MAX_ROLLS > 0) ? $clog2(MAX_ROLLS + 1) : 1;

  localparam logic [DW-1:0]   DIE_ONE  = DW'(1);
  localparam logic [DW-1:0]   DIE_MAX  = DW'(FACES);
  localparam logic [CNTW-1:0] LIMIT_M1 = CNTW'((MAX_ROLLS > 0) ? MAX_ROLLS - 1 : 0);
  localparam logic [6:0]      BLANK    = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

  typedef enum logic [1:0] {S_FIRST, S_POINT, S_WIN, S_LOSE} state_t;

  state_t          state;
  logic            sync1, roll_s, roll_d;
  logic            rel;
  logic [DW-1:0]   die1, die2;
  logic [SUMW-1:0] sum;
  logic [4:0]      sum_w;
  logic            natural, craps;
  logic [SUMW-1:0] point_q;
  logic [CNTW-1:0] rollcnt;
  logic            win_q, lose_q, pv_q;
  logic [6:0]      disp1_q, disp2_q;

  function automatic logic [6:0] seg(input logic [DW-1:0] v);
    logic [6:0] s;
    case (4'(v))
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return SEG_ACTIVE_LOW ? ~s : s;
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1  <= 1'b0;
      roll_s <= 1'b0;
      roll_d <= 1'b0;
    end else begin
      sync1  <= bus.roll;
      roll_s <= sync1;
      roll_d <= roll_s;
    end
  end

  assign rel = roll_d & ~roll_s;

  // die2 carries off die1's wrap, so the pair behaves as one base-FACES counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      die1 <= DIE_ONE;
      die2 <= DIE_ONE;
    end else if (roll_s) begin
      if (die1 == DIE_MAX) begin
        die1 <= DIE_ONE;
        die2 <= (die2 == DIE_MAX) ? DIE_ONE : die2 + DIE_ONE;
      end else begin
        die1 <= die1 + DIE_ONE;
      end
    end
  end

  assign sum = SUMW'(die1) + SUMW'(die2);

  // Compare in a fixed 5-bit space: with small FACES, SUMW is too narrow
  // to hold 7 or 11, and truncating those constants would alias real sums.
  assign sum_w   = 5'(sum);
  assign natural = (sum_w == 5'd7) || (sum_w == 5'd11);
  assign craps   = (sum_w == 5'd2) || (sum_w == 5'd3) || (sum_w == 5'(2 * FACES));

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= S_FIRST;
      win_q   <= 1'b0;
      lose_q  <= 1'b0;
      pv_q    <= 1'b0;
      point_q <= '0;
      rollcnt <= '0;
      disp1_q <= BLANK;
      disp2_q <= BLANK;
    end else if (rel) begin
      disp1_q <= seg(die1);
      disp2_q <= seg(die2);
      case (state)
        S_FIRST: begin
          if (natural) begin
            state <= S_WIN;
            win_q <= 1'b1;
          end else if (craps) begin
            state  <= S_LOSE;
            lose_q <= 1'b1;
          end else begin
            state   <= S_POINT;
            pv_q    <= 1'b1;
            point_q <= sum;
            rollcnt <= '0;
          end
        end
        S_POINT: begin
          if (sum == point_q) begin
            state <= S_WIN;
            win_q <= 1'b1;
            pv_q  <= 1'b0;
          end else if (sum_w == 5'd7 ||
                       (MAX_ROLLS > 0 && rollcnt == LIMIT_M1)) begin
            state  <= S_LOSE;
            lose_q <= 1'b1;
            pv_q   <= 1'b0;
          end else begin
            rollcnt <= rollcnt + CNTW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.disp1       = disp1_q;
  assign bus.disp2       = disp2_q;
  assign bus.win         = win_q;
  assign bus.lose        = lose_q;
  assign bus.point       = point_q;
  assign bus.point_valid = pv_q;
endmodule

// File: doc/dice_craps_engine.md
Name: dice_craps_engine

Overview:
Parametrised craps game engine for the board-level dice game. It replaces the fixed two-display win/lose block with a self-contained FSM, two on-chip dice counters, a roll-button synchroniser, point tracking and an optional roll limit. It drives two 7-segment digits (one per die) and the win/lose LEDs, and exports the current point for a third display or a debug output.

Parameters:
FACES, 6, faces per die; legal range 2..9, so each value fits one 7-segment digit.
MAX_ROLLS, 0, point-phase roll limit; 0 = unlimited; N>0 = LOSE when the Nth point-phase roll misses.
SEG_ACTIVE_LOW, 1, 1 = segment lit by 0; 0 = segment lit by 1.
SUMW, derived = clog2(2*FACES+1), width of a dice sum; not user-set.

Ports:
clock  in  1  system clock; single clock domain.
reset  in  1  synchronous, active-high reset.
roll  in  1  raw roll button, asynchronous, 1 = pressed; the roll completes on release.
disp1  out  7  die 1 segments, {g,f,e,d,c,b,a}.
disp2  out  7  die 2 segments, {g,f,e,d,c,b,a}.
win  out  1  green LED, registered.
lose  out  1  red LED, registered.
point  out  SUMW  established point; 0 when none.
point_valid  out  1  1 while in the POINT state.

Behaviour:
- Synchroniser: roll passes through 2 flops to give roll_s; roll_d = roll_s delayed 1 cycle; release = roll_d & ~roll_s.
- Dice counters (die1, die2, range 1..FACES):
  - Reset value is 1 for both.
  - While roll_s=1, die1 increments every cycle and wraps FACES->1.
  - die2 increments (same wrap) in the cycle die1 wraps.
  - Counters hold while roll_s=0 and are never cleared between rolls.
- sum = die1 + die2, SUMW bits, no overflow possible.
- FSM states: FIRST, POINT, WIN, LOSE. All transitions happen on the edge where release=1.
  - FIRST:
    - sum in {7, 11} -> WIN.
    - sum in {2, 3, 2*FACES} -> LOSE.
    - Otherwise -> POINT; point<=sum; rollcnt<=0.
  - POINT:
    - sum==point -> WIN.
    - sum==7 -> LOSE.
    - Otherwise rollcnt++. If MAX_ROLLS>0 and rollcnt+1==MAX_ROLLS -> LOSE.
    - sum==point takes priority over the limit.
  - WIN and LOSE are terminal. Roll presses and releases are ignored except that the dice keep cycling. Only reset leaves these states.
- Display registers:
  - Load seg(die1) and seg(die2) on every release, including in WIN/LOSE, so the last throw always shows.
  - Hold between releases.
  - Reset: all segments off (7'h7F if SEG_ACTIVE_LOW, else 7'h00).
- Segment encoding, active-high form {g..a}: 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F. Invert all bits when SEG_ACTIVE_LOW=1.
- Output encoding:
  - win = (state==WIN); lose = (state==LOSE); point_valid = (state==POINT).
  - point = 0 except in POINT, WIN-from-POINT and LOSE-from-POINT, where it holds the established value.
- Latency: if roll is first sampled low at edge k, then roll_s=0 after k+1. The state, LEDs and displays update at edge k+2 and are visible after it.
- Reset values: state=FIRST, win=0, lose=0, point=0, point_valid=0, rollcnt=0, die1=die2=1, displays blank, synchroniser flops 0.
- Reset mid-roll (button still held): return to the reset values. Counting resumes once roll_s is 1 again after reset deasserts. A release spanning a reset cycle is discarded.
- Glitch of a single-cycle roll_s=1: counts as a roll (die1 advances 1), no debounce filtering in this block.

Test Plan:
- Reset, then hold roll_s high 5 cycles and release -> die1=6, die2=1, sum 7; win=1 at release+1 edge; disp1=~7D, disp2=~06 (active-low).
- Reset, hold 1 cycle and release -> sum 3 (2+1); lose=1, point=0, point_valid=0.
- Reset, hold 4 cycles (5+1=6) -> POINT, point=6, point_valid=1. Hold 6 more cycles (cumulative 10 -> die1=5, die2=2, sum 7) -> lose=1, point stays 6.
- Reset, hold 4 (point 6). Hold 1 (die1=6, die2=1, sum 7)? Instead hold 2 more (cumulative 6 -> die1=1, die2=2, sum 3) -> still POINT. Hold 3 more (cumulative 9 -> die1=4, die2=2, sum 6) -> win=1.
- MAX_ROLLS=2: reset, point 6 as above, then two non-7, non-6 rolls (cumulative 6 -> sum 3; cumulative 7 -> sum 4) -> lose=1 on the 2nd miss.
- In WIN: further press/release -> win stays 1, displays update. Assert reset while roll is held -> all outputs return to reset values the next cycle.
